// File: rtl/mac_pe_chain_if.sv
// rtl/mac_pe_chain_if.sv - weight/data handshake and psum bundle for mac_pe_chain
interface mac_pe_chain_if #(
    parameter int NUM_PE = 4,
    parameter int DW     = 8,
    parameter int WW     = 8,
    parameter int PSW    = 32
);
    logic                   w_valid;
    logic [WW-1:0]          w_in;
    logic                   w_ready;
    logic                   d_valid;
    logic                   d_ready;
    logic [NUM_PE*DW-1:0]   d_in;
    logic [NUM_PE-1:0]      en_mask;
    logic [PSW-1:0]         ps_in;
    logic                   zero_en;
    logic [PSW-1:0]         ps_out;
    logic                   ps_out_valid;
    logic                   sat_flag;

    modport master (
        output w_valid, w_in, d_valid, d_in, en_mask, ps_in, zero_en,
        input  w_ready, d_ready, ps_out, ps_out_valid, sat_flag
    );

    modport slave (
        input  w_valid, w_in, d_valid, d_in, en_mask, ps_in, zero_en,
        output w_ready, d_ready, ps_out, ps_out_valid, sat_flag
    );
endinterface

// File: rtl/mac_pe_chain.sv
// rtl/mac_pe_chain.sv - weight-stationary signed MAC chain, one conv column
// Define MAC_SAT_EN for saturating per-PE adds and a sticky sat_flag; otherwise adds wrap.
module mac_pe_chain #(
    parameter int NUM_PE = 4,
    parameter int DW     = 8,
    parameter int WW     = 8,
    parameter int PSW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    mac_pe_chain_if.slave bus
);
    localparam int CW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int PW = DW + WW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          w_cnt_q, w_cnt_d;
    logic signed [WW-1:0]   w_q [NUM_PE];
    logic signed [WW-1:0]   w_d [NUM_PE];
    logic [NUM_PE-1:0]      v_q, v_d;
    logic signed [PSW-1:0]  ps_q [NUM_PE];
    logic signed [PSW-1:0]  ps_d [NUM_PE];

    logic                   pipe_empty;
    logic                   w_acc;
    logic                   d_acc;
    logic                   w_last;
    logic [NUM_PE*DW-1:0]   lane_data;
    logic [NUM_PE-1:0]      lane_en;
    logic signed [DW-1:0]   dsel [NUM_PE];
    logic signed [PW-1:0]   prod [NUM_PE];
    logic signed [PSW-1:0]  prod_x [NUM_PE];
    logic signed [PSW-1:0]  ps_prev [NUM_PE];
    logic signed [PSW-1:0]  sum [NUM_PE];
    logic [NUM_PE-1:0]      v_in;
`ifdef MAC_SAT_EN
    logic [PSW:0]           wide [NUM_PE];
    logic [NUM_PE-1:0]      ovf;
    logic                   sat_q, sat_d;
`endif

    // Weights may only be rewritten once every in-flight vector has left the chain.
    assign pipe_empty  = (v_q == '0);
    assign bus.w_ready = (state_q != READY) | pipe_empty;
    assign w_acc       = bus.w_valid & bus.w_ready;
    assign bus.d_ready = (state_q == READY) & ~w_acc;
    assign d_acc       = bus.d_valid & bus.d_ready & ~bus.zero_en;
    assign w_last      = (w_cnt_q == CW'(NUM_PE - 1));

    assign lane_data[DW-1:0] = bus.d_in[DW-1:0];
    assign lane_en[0]        = bus.en_mask[0];

    // Lane k (data plus its enable bit) is delayed by k registers so it meets its psum at PE k.
    for (genvar k = 1; k < NUM_PE; k++) begin : g_skew
        logic [DW:0] sk_q [k];
        logic [DW:0] sk_d [k];

        always_comb begin
            for (int j = 0; j < k; j++) begin
                sk_d[j] = sk_q[j];
            end
            if (bus.zero_en) begin
                for (int j = 0; j < k; j++) begin
                    sk_d[j] = '0;
                end
            end else begin
                sk_d[0] = d_acc ? {bus.en_mask[k], bus.d_in[k*DW +: DW]} : '0;
                for (int j = 1; j < k; j++) begin
                    sk_d[j] = sk_q[j-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int j = 0; j < k; j++) begin
                    sk_q[j] <= '0;
                end
            end else begin
                for (int j = 0; j < k; j++) begin
                    sk_q[j] <= sk_d[j];
                end
            end
        end

        assign lane_data[k*DW +: DW] = sk_q[k-1][DW-1:0];
        assign lane_en[k]            = sk_q[k-1][DW];
    end

    always_comb begin
        ps_prev[0] = bus.ps_in;
        v_in[0]    = d_acc;
        for (int k = 1; k < NUM_PE; k++) begin
            ps_prev[k] = ps_q[k-1];
            v_in[k]    = v_q[k-1];
        end
        for (int k = 0; k < NUM_PE; k++) begin
            dsel[k]   = lane_en[k] ? lane_data[k*DW +: DW] : '0;
            prod[k]   = PW'(w_q[k]) * PW'(dsel[k]);
            prod_x[k] = PSW'(prod[k]);
`ifdef MAC_SAT_EN
            // One guard bit: overflow when the top two bits of the widened sum disagree.
            wide[k] = {ps_prev[k][PSW-1], ps_prev[k]} + {prod_x[k][PSW-1], prod_x[k]};
            ovf[k]  = wide[k][PSW] ^ wide[k][PSW-1];
            if (ovf[k]) begin
                sum[k] = wide[k][PSW] ? {1'b1, {(PSW-1){1'b0}}} : {1'b0, {(PSW-1){1'b1}}};
            end else begin
                sum[k] = wide[k][PSW-1:0];
            end
`else
            sum[k] = ps_prev[k] + prod_x[k];
`endif
            v_d[k]  = bus.zero_en ? 1'b0 : v_in[k];
            ps_d[k] = bus.zero_en ? '0 : (v_in[k] ? sum[k] : ps_q[k]);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_PE; k++) begin
            w_d[k] = w_q[k];
            if (w_acc && (w_cnt_q == CW'(k))) begin
                w_d[k] = bus.w_in;
            end
        end
        w_cnt_d = w_cnt_q;
        if (w_acc) begin
            w_cnt_d = w_last ? '0 : w_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q     <= '0;
            w_cnt_q <= '0;
            for (int k = 0; k < NUM_PE; k++) begin
                ps_q[k] <= '0;
                w_q[k]  <= '0;
            end
        end else begin
            v_q     <= v_d;
            w_cnt_q <= w_cnt_d;
            for (int k = 0; k < NUM_PE; k++) begin
                ps_q[k] <= ps_d[k];
                w_q[k]  <= w_d[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (w_acc) state_q <= LOAD;
                LOAD:    if (w_acc && w_last) state_q <= READY;
                READY:   if (w_acc) state_q <= LOAD;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MAC_SAT_EN
    // The first word of a new weight set starts a fresh saturation window.
    always_comb begin
        sat_d = sat_q;
        if (w_acc && (w_cnt_q == '0)) begin
            sat_d = 1'b0;
        end else if (!bus.zero_en && ((ovf & v_in) != '0)) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign bus.sat_flag = sat_q;
`else
    assign bus.sat_flag = 1'b0;
`endif

    assign bus.ps_out       = ps_q[NUM_PE-1];
    assign bus.ps_out_valid = v_q[NUM_PE-1];
endmodule

// File: tb/tb_mac_pe_chain.sv
// tb/tb_mac_pe_chain.sv - scoreboard bench for mac_pe_chain against an arithmetic model
module tb_mac_pe_chain;
    localparam int NUM_PE = 4;
    localparam int DW     = 8;
    localparam int WW     = 8;
    localparam int PSW    = 16;
`ifdef MAC_SAT_EN
    localparam longint PS_MAX  = (longint'(1) << (PSW - 1)) - 1;
    localparam longint PS_MIN  = -(longint'(1) << (PSW - 1));
    localparam longint T6_PS   = 32767;
    localparam longint T6_SAT  = 1;
`else
    localparam longint T6_PS   = -32768;
    localparam longint T6_SAT  = 0;
`endif

    typedef struct {
        longint v;
        int     c;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    exp_t   q[$];
    int     w_model [NUM_PE];
    bit     sat_model = 1'b0;
    int     last_acc = -100;
    longint prev_out = 0;
    bit     zflush = 1'b0;

    mac_pe_chain_if #(.NUM_PE(NUM_PE), .DW(DW), .WW(WW), .PSW(PSW)) bus ();

    mac_pe_chain #(.NUM_PE(NUM_PE), .DW(DW), .WW(WW), .PSW(PSW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [31:0] pk(input int a0, input int a1, input int a2, input int a3);
        logic [31:0] r;
        r = {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
        return r;
    endfunction

    // Reference: psum passes PE0..PE(N-1), each adding w[k]*(en?d:0), then wraps or clamps.
    function automatic longint model(input logic [NUM_PE*DW-1:0] d, input logic [NUM_PE-1:0] m,
                                     input logic [PSW-1:0] p);
        longint s;
        logic signed [PSW-1:0] t;
        s = longint'($signed(p));
        for (int k = 0; k < NUM_PE; k++) begin
            int dv;
            dv = $signed(d[k*DW +: DW]);
            s = s + (m[k] ? longint'(w_model[k] * dv) : 0);
`ifdef MAC_SAT_EN
            if (s > PS_MAX) begin
                s = PS_MAX;
                sat_model = 1'b1;
            end else if (s < PS_MIN) begin
                s = PS_MIN;
                sat_model = 1'b1;
            end
`else
            t = s[PSW-1:0];
            s = longint'(t);
`endif
        end
        return s;
    endfunction

    // Monitor: pops an expectation for every valid output, otherwise checks ps_out is held.
    always @(negedge clk) begin
        if (!rst) begin
            prev_out = 0;
            zflush   = 1'b0;
        end else begin
            if (bus.ps_out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_ps_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ps_out", longint'($signed(bus.ps_out)), e.v);
                    chk("latency", longint'(cyc - e.c), NUM_PE - 1);
                end
            end else begin
                chk("ps_out_hold", longint'($signed(bus.ps_out)), zflush ? 0 : prev_out);
            end
            prev_out = longint'($signed(bus.ps_out));
            zflush   = bus.zero_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights(input logic [NUM_PE*WW-1:0] wp);
        for (int k = 0; k < NUM_PE; k++) begin
            bit ok;
            int n;
            ok = 1'b0;
            n  = 0;
            bus.w_valid = 1'b1;
            bus.w_in    = wp[k*WW +: WW];
            while (!ok && n < 100) begin
                @(negedge clk);
                ok = bus.w_ready;
                n++;
                tick();
            end
            if (!ok) begin
                chk("w_accept_timeout", 0, 1);
            end else begin
                w_model[k] = $signed(wp[k*WW +: WW]);
                if (k == 0) sat_model = 1'b0;
            end
        end
        bus.w_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [NUM_PE*DW-1:0] d, input logic [NUM_PE-1:0] m,
                            input logic [PSW-1:0] p, input bit use_exp, input longint exp_v);
        bit acc;
        int n;
        longint v;
        acc = 1'b0;
        n   = 0;
        bus.d_valid = 1'b1;
        bus.d_in    = d;
        bus.en_mask = m;
        bus.ps_in   = p;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.d_ready && bus.d_valid && !bus.zero_en;
            n++;
            tick();
        end
        bus.d_valid = 1'b0;
        if (!acc) begin
            chk("d_accept_timeout", 0, 1);
        end else begin
            v = model(d, m, p);
            if (use_exp) v = exp_v;
            q.push_back('{v: v, c: cyc});
            last_acc = cyc;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) tick();
        repeat (2) tick();
        chk("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        bus.w_valid = 1'b0;
        bus.w_in    = '0;
        bus.d_valid = 1'b0;
        bus.d_in    = '0;
        bus.en_mask = '0;
        bus.ps_in   = '0;
        bus.zero_en = 1'b0;
        for (int k = 0; k < NUM_PE; k++) w_model[k] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ps_out", bus.ps_out, 0);
        chk("rst_ps_out_valid", bus.ps_out_valid, 0);
        chk("rst_sat_flag", bus.sat_flag, 0);
        chk("rst_w_ready", bus.w_ready, 1);
        chk("rst_d_ready", bus.d_ready, 0);
        tick();
        rst = 1'b1;

        // Data offered in IDLE is ignored.
        bus.d_valid = 1'b1;
        bus.d_in    = pk(1, 1, 1, 1);
        bus.en_mask = 4'hF;
        repeat (3) begin
            @(negedge clk);
            chk("idle_d_ready", bus.d_ready, 0);
            tick();
        end
        bus.d_valid = 1'b0;

        // 1: single vector
        load_weights(pk(1, 2, 3, 4));
        send_vec(pk(1, 1, 1, 1), 4'hF, 16'd0, 1'b1, 10);
        drain();

        // 2: back-to-back, then with a bubble
        send_vec(pk(1, 1, 1, 1), 4'hF, 16'd5, 1'b1, 15);
        send_vec(pk(2, 0, -1, 3), 4'hF, 16'd5, 1'b1, 16);
        send_vec(pk(1, 1, 1, 1), 4'hF, 16'd5, 1'b1, 15);
        tick();
        send_vec(pk(2, 0, -1, 3), 4'hF, 16'd5, 1'b1, 16);
        drain();

        // 3: lane mask with extreme weights
        load_weights(pk(-128, 127, 2, -1));
        send_vec(pk(-128, -1, 5, 7), 4'b1010, 16'd0, 1'b1, -134);
        drain();

        // 4: weight load requested while two vectors are in flight
        send_vec(pk(1, 2, 3, 4), 4'hF, 16'd0, 1'b1, 128);
        send_vec(pk(1, 1, 1, 1), 4'hF, 16'd0, 1'b1, 0);
        bus.w_valid = 1'b1;
        bus.w_in    = 8'd4;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                chk("w_ready_inflight", bus.w_ready, (cyc >= last_acc + NUM_PE) ? 1 : 0);
                seen = bus.w_ready;
                if (seen) bus.w_valid = 1'b0;
                tick();
            end
            if (!seen) chk("w_ready_timeout", 0, 1);
        end
        load_weights(pk(4, 3, 2, 1));
        send_vec(pk(1, 2, 3, 4), 4'hF, 16'd0, 1'b1, 20);
        drain();

        // 5: flush after two accepts, and flush colliding with an accept
        send_vec(pk(1, 1, 1, 1), 4'hF, 16'd0, 1'b1, 10);
        send_vec(pk(2, 2, 2, 2), 4'hF, 16'd0, 1'b1, 20);
        bus.zero_en = 1'b1;
        tick();
        bus.zero_en = 1'b0;
        q.delete();
        bus.d_valid = 1'b1;
        bus.zero_en = 1'b1;
        tick();
        bus.d_valid = 1'b0;
        bus.zero_en = 1'b0;
        repeat (6) tick();
        send_vec(pk(1, 0, 0, 0), 4'hF, 16'd100, 1'b1, 104);
        drain();

        // 6: overflow at PE0
        load_weights(pk(1, 0, 0, 0));
        send_vec(pk(1, 0, 0, 0), 4'hF, 16'd32767, 1'b1, T6_PS);
        drain();
        chk("t6_sat_flag", bus.sat_flag, T6_SAT);

        // Randomized traffic with bubbles and occasional reloads
        load_weights($urandom());
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 39) == 0) load_weights($urandom());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
            send_vec($urandom(), 4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)), 1'b0, 0);
        end
        drain();
        chk("rand_sat_flag", bus.sat_flag, sat_model);

        // Reset pulse in the middle of a weight load
        bus.w_valid = 1'b1;
        bus.w_in    = 8'd9;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_w_ready", bus.w_ready, 1);
        chk("midrst_d_ready", bus.d_ready, 0);
        chk("midrst_ps_out_valid", bus.ps_out_valid, 0);
        chk("midrst_sat_flag", bus.sat_flag, 0);
        bus.w_valid = 1'b0;
        q.delete();
        sat_model = 1'b0;
        for (int k = 0; k < NUM_PE; k++) w_model[k] = 0;
        tick();
        rst = 1'b1;
        load_weights(pk(5, 6, 7, 8));
        send_vec(pk(1, 0, 0, 0), 4'hF, 16'd0, 1'b1, 5);
        send_vec(pk(0, 0, 0, 1), 4'hF, 16'd0, 1'b1, 8);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
